alu_ctrl: RTL and testbench

Sequencing front end for the 16-bit combinational ALU (Z = X + Y; flags S, ZR, CY, P, V). It accepts operand pairs over a valid/ready handshake and registers them onto the ALU inputs. After a programmable settle time it captures Z and the five flags into a result FIFO, which drains over a second valid/ready handshake. It also keeps an operation counter and a sticky flag accumulator, and sits between the instruction/test sequencer and the ALU instance.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_res_fifo.sv | 70 +++++++
 rtl/alu_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing front end.
//   DATA_W / FLAGS_W : operand/result width and flag-vector width
//   FLG_*            : bit positions inside the packed {S, ZR, CY, P, V} flag vector
//   ctrl_state_e     : alu_ctrl FSM encoding
package alu_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FLAGS_W = 5;

  localparam int unsigned FLG_S  = 4;
  localparam int unsigned FLG_ZR = 3;
  localparam int unsigned FLG_CY = 2;
  localparam int unsigned FLG_P  = 1;
  localparam int unsigned FLG_V  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCapture
  } ctrl_state_e;

endpackage

// File: rtl/alu_res_fifo.sv
// Result FIFO for alu_ctrl: synchronous, count-based full/empty, fall-through head.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   push_i, wdata_i  : write request and data (ignored when full)
//   pop_i            : remove head (ignored when empty)
//   rdata_o          : head entry, forced to zero while empty
//   empty_o, full_o  : occupancy status
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W + FLAGS_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing front end for the 16-bit combinational ALU.
// Accepts operand pairs, holds them on the ALU inputs for SETTLE cycles, captures
// {Z, flags} into a result FIFO, and keeps an operation counter and sticky flags.
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o          : operand handshake, operands in_x_i / in_y_i
//   alu_x_o, alu_y_o               : registered drive to the ALU
//   alu_z_i, alu_flags_i           : ALU result and {S, ZR, CY, P, V}
//   out_valid_o/out_ready_i        : result handshake, head in out_z_o / out_flags_o
//   op_count_o                     : completed captures, wrapping
//   sticky_flags_o, sticky_clr_i   : OR of captured flags, synchronous clear
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  in_x_i,
  input  logic [DATA_W-1:0]  in_y_i,
  output logic [DATA_W-1:0]  alu_x_o,
  output logic [DATA_W-1:0]  alu_y_o,
  input  logic [DATA_W-1:0]  alu_z_i,
  input  logic [FLAGS_W-1:0] alu_flags_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  out_z_o,
  output logic [FLAGS_W-1:0] out_flags_o,
  output logic [15:0]        op_count_o,
  output logic [FLAGS_W-1:0] sticky_flags_o,
  input  logic               sticky_clr_i
);

  localparam logic [3:0] SettleInit = 4'(SETTLE - 1);

  ctrl_state_e state_q, state_d;

  logic [DATA_W-1:0]  alu_x_q, alu_x_d;
  logic [DATA_W-1:0]  alu_y_q, alu_y_d;
  logic [3:0]         settle_cnt_q, settle_cnt_d;
  logic [15:0]        op_count_q, op_count_d;
  logic [FLAGS_W-1:0] sticky_q, sticky_d;

  logic accept;
  logic capture;
  logic fifo_full;
  logic fifo_empty;
  logic [DATA_W+FLAGS_W-1:0] fifo_rdata;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StDrive;
      StDrive:   if (settle_cnt_q == '0) state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM: outputs. Intake is refused while full, so CAPTURE always finds space.
  always_comb begin
    in_ready_o = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StIdle:    in_ready_o = ~fifo_full;
      StDrive:   in_ready_o = 1'b0;
      StCapture: capture    = 1'b1;
      default:   in_ready_o = 1'b0;
    endcase
  end

  assign accept = in_valid_i & in_ready_o;

  // Datapath next state
  always_comb begin
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    settle_cnt_d = settle_cnt_q;
    op_count_d   = op_count_q;
    sticky_d     = sticky_q;

    if (accept) begin
      alu_x_d      = in_x_i;
      alu_y_d      = in_y_i;
      settle_cnt_d = SettleInit;
    end else if ((state_q == StDrive) && (settle_cnt_q != '0)) begin
      settle_cnt_d = settle_cnt_q - 4'd1;
    end

    if (capture) op_count_d = op_count_q + 16'd1;

    // Clear takes effect before the OR, so a coincident capture survives it.
    if (sticky_clr_i) sticky_d = '0;
    if (capture)      sticky_d = sticky_d | alu_flags_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      settle_cnt_q <= '0;
      op_count_q   <= '0;
      sticky_q     <= '0;
    end else begin
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      settle_cnt_q <= settle_cnt_d;
      op_count_q   <= op_count_d;
      sticky_q     <= sticky_d;
    end
  end

  alu_res_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DATA_W + FLAGS_W)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (capture),
    .wdata_i ({alu_z_i, alu_flags_i}),
    .pop_i   (out_ready_i),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign alu_x_o        = alu_x_q;
  assign alu_y_o        = alu_y_q;
  assign out_valid_o    = ~fifo_empty;
  assign out_z_o        = fifo_rdata[DATA_W+FLAGS_W-1:FLAGS_W];
  assign out_flags_o    = fifo_rdata[FLAGS_W-1:0];
  assign op_count_o     = op_count_q;
  assign sticky_flags_o = sticky_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: two instances (SETTLE = 1 and SETTLE = 3), each driving
// a behavioural ALU (Z = X + Y, flags {S, ZR, CY, P(even), V}).
module tb_alu_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance, SETTLE = 1, DEPTH = 4
  logic        in_valid, in_ready, out_valid, out_ready, sticky_clr;
  logic [15:0] in_x, in_y, alu_x, alu_y, alu_z, out_z, op_count;
  logic [4:0]  alu_flags, out_flags, sticky;
  logic [16:0] sum;

  assign sum       = {1'b0, alu_x} + {1'b0, alu_y};
  assign alu_z     = sum[15:0];
  assign alu_flags = {alu_z[15], alu_z == 16'h0, sum[16], ~^alu_z,
                      (alu_x[15] == alu_y[15]) && (alu_z[15] != alu_x[15])};

  alu_ctrl #(.SETTLE(1), .DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_x_i         (in_x),
    .in_y_i         (in_y),
    .alu_x_o        (alu_x),
    .alu_y_o        (alu_y),
    .alu_z_i        (alu_z),
    .alu_flags_i    (alu_flags),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_z_o        (out_z),
    .out_flags_o    (out_flags),
    .op_count_o     (op_count),
    .sticky_flags_o (sticky),
    .sticky_clr_i   (sticky_clr)
  );

  // Second instance, SETTLE = 3
  logic        in_valid3, in_ready3, out_valid3;
  logic [15:0] in_x3, in_y3, alu_x3, alu_y3, alu_z3, out_z3, op_count3;
  logic [4:0]  alu_flags3, out_flags3, sticky3;
  logic [16:0] sum3;

  assign sum3       = {1'b0, alu_x3} + {1'b0, alu_y3};
  assign alu_z3     = sum3[15:0];
  assign alu_flags3 = {alu_z3[15], alu_z3 == 16'h0, sum3[16], ~^alu_z3,
                       (alu_x3[15] == alu_y3[15]) && (alu_z3[15] != alu_x3[15])};

  alu_ctrl #(.SETTLE(3), .DEPTH(4)) dut3 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid3),
    .in_ready_o     (in_ready3),
    .in_x_i         (in_x3),
    .in_y_i         (in_y3),
    .alu_x_o        (alu_x3),
    .alu_y_o        (alu_y3),
    .alu_z_i        (alu_z3),
    .alu_flags_i    (alu_flags3),
    .out_valid_o    (out_valid3),
    .out_ready_i    (1'b1),
    .out_z_o        (out_z3),
    .out_flags_o    (out_flags3),
    .op_count_o     (op_count3),
    .sticky_flags_o (sticky3),
    .sticky_clr_i   (1'b0)
  );

  // Results leaving the main instance, in pop order
  logic [20:0] got_q [$];

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) got_q.push_back({out_z, out_flags});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_res();
    if (got_q.size() == 0) return 32'hFFFF_FFFF;
    return 32'(got_q.pop_front());
  endfunction

  // Offer one operand pair at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y);
    bit ok;
    ok       = 1'b0;
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("accept", 32'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    out_ready  = 1'b1;
    sticky_clr = 1'b0;
    in_valid3  = 1'b0;
    in_x3      = '0;
    in_y3      = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_z", 32'(out_z), 0);
    check_eq("rst_out_flags", 32'(out_flags), 0);
    check_eq("rst_op_count", 32'(op_count), 0);
    check_eq("rst_sticky", 32'(sticky), 0);
    check_eq("rst_alu_x", 32'(alu_x), 0);
    check_eq("rst_alu_y", 32'(alu_y), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_in_ready3", 32'(in_ready3), 1);

    // Single op: 8FFF + 8000 = 0FFF, CY and V, even parity
    got_q.delete();
    send(16'h8FFF, 16'h8000);
    check_eq("single_alu_x", 32'(alu_x), 'h8FFF);
    check_eq("single_lat0", 32'(out_valid), 0);
    @(negedge clk);
    check_eq("single_lat1", 32'(out_valid), 0);
    @(negedge clk);
    check_eq("single_lat2", 32'(out_valid), 1);
    check_eq("single_z", 32'(out_z), 'h0FFF);
    check_eq("single_flags", 32'(out_flags), 'b00111);
    check_eq("single_count", 32'(op_count), 1);
    check_eq("single_sticky", 32'(sticky), 'b00111);
    @(negedge clk);
    check_eq("single_popped", 32'(out_valid), 0);

    // Back-to-back
    got_q.delete();
    send(16'h0001, 16'h0002);
    send(16'h8000, 16'h8000);
    repeat (4) @(negedge clk);
    check_eq("b2b_n", 32'(got_q.size()), 2);
    check_eq("b2b_r0", pop_res(), {16'h0003, 5'b00010});
    check_eq("b2b_r1", pop_res(), {16'h0000, 5'b01111});
    check_eq("b2b_count", 32'(op_count), 3);
    check_eq("b2b_sticky", 32'(sticky), 'b01111);

    // Backpressure: four ops fill the FIFO, the fifth stalls until drain
    got_q.delete();
    out_ready = 1'b0;
    send(16'h1111, 16'h2222);
    send(16'h7FFF, 16'h0001);
    send(16'hFFFF, 16'h0001);
    send(16'h4000, 16'h4000);
    repeat (2) @(negedge clk);
    check_eq("bp_full_ready", 32'(in_ready), 0);
    check_eq("bp_head_valid", 32'(out_valid), 1);
    check_eq("bp_head_z", 32'(out_z), 'h3333);
    check_eq("bp_count4", 32'(op_count), 7);
    in_x     = 16'h0F0F;
    in_y     = 16'h0101;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("bp_stall_ready", 32'(in_ready), 0);
    check_eq("bp_stall_count", 32'(op_count), 7);
    out_ready = 1'b1;
    send(16'h0F0F, 16'h0101);
    repeat (12) @(negedge clk);
    check_eq("bp_n", 32'(got_q.size()), 5);
    check_eq("bp_r0", pop_res(), {16'h3333, 5'b00010});
    check_eq("bp_r1", pop_res(), {16'h8000, 5'b10001});
    check_eq("bp_r2", pop_res(), {16'h0000, 5'b01110});
    check_eq("bp_r3", pop_res(), {16'h8000, 5'b10001});
    check_eq("bp_r4", pop_res(), {16'h1010, 5'b00010});
    check_eq("bp_count5", 32'(op_count), 8);

    // Async reset while in DRIVE
    got_q.delete();
    send(16'h1234, 16'h1111);
    check_eq("ar_alu_x_pre", 32'(alu_x), 'h1234);
    #1 rst_n = 1'b0;
    #1;
    check_eq("ar_alu_x", 32'(alu_x), 0);
    check_eq("ar_alu_y", 32'(alu_y), 0);
    check_eq("ar_count", 32'(op_count), 0);
    check_eq("ar_sticky", 32'(sticky), 0);
    check_eq("ar_out_valid", 32'(out_valid), 0);
    check_eq("ar_out_z", 32'(out_z), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("ar_discard_n", 32'(got_q.size()), 0);
    check_eq("ar_discard_valid", 32'(out_valid), 0);
    check_eq("ar_discard_count", 32'(op_count), 0);
    check_eq("ar_in_ready", 32'(in_ready), 1);

    // sticky_clr coincident with CAPTURE
    send(16'h8000, 16'h8000);
    repeat (3) @(negedge clk);
    check_eq("sc_sticky_pre", 32'(sticky), 'b01111);
    send(16'h0001, 16'h0002);
    @(negedge clk);
    check_eq("sc_in_capture", 32'(in_ready), 0);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check_eq("sc_sticky", 32'(sticky), 'b00010);
    check_eq("sc_count", 32'(op_count), 2);

    // SETTLE = 3: latency 4, operands held through DRIVE
    in_x3     = 16'h7FFF;
    in_y3     = 16'h7FFF;
    in_valid3 = 1'b1;
    check_eq("s3_ready", 32'(in_ready3), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid3 = 1'b0;
    in_x3     = 16'hAAAA;
    in_y3     = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      check_eq("s3_lat", 32'(out_valid3), 0);
      check_eq("s3_hold_x", 32'(alu_x3), 'h7FFF);
      check_eq("s3_hold_y", 32'(alu_y3), 'h7FFF);
      @(negedge clk);
    end
    check_eq("s3_valid", 32'(out_valid3), 1);
    check_eq("s3_z", 32'(out_z3), 'hFFFE);
    check_eq("s3_flags", 32'(out_flags3), 'b10001);
    check_eq("s3_count", 32'(op_count3), 1);
    check_eq("s3_sticky", 32'(sticky3), 'b10001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
